// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and pixel colour type, used by the
// timing stage and the bouncing-sprite overlay.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef logic [2:0] rgb_t;

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of sprite motion: position/direction register with clamp-and-bounce
// at 0 and at limit. bounce is combinational so the colour can advance on the same tick.
module vga_bounce_axis #(
  parameter int STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic [9:0] limit,
  output logic [9:0] pos,
  output logic       dir,
  output logic       bounce
);

  logic [10:0] fwd;
  logic        hit_hi;
  logic        hit_lo;

  // 11-bit sum so pos+STEP cannot wrap before the limit compare
  assign fwd    = {1'b0, pos} + 11'(STEP);
  assign hit_hi = fwd > {1'b0, limit};
  assign hit_lo = pos < 10'(STEP);
  assign bounce = upd && (dir ? hit_hi : hit_lo);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
      dir <= 1'b1;
    end else if (upd) begin
      if (dir) begin
        if (hit_hi) begin
          pos <= limit;
          dir <= 1'b0;
        end else begin
          pos <= fwd[9:0];
        end
      end else begin
        if (hit_lo) begin
          pos <= '0;
          dir <= 1'b1;
        end else begin
          pos <= pos - 10'(STEP);
        end
      end
    end
  end

endmodule

// File: rtl/vga_bounce.sv
// Square sprite bouncing around the active area, composited over the timing
// stage's background. Define VGA_BOUNCE_COLOR_CYCLE_EN to cycle colour per bounce.
module vga_bounce #(
  parameter int SIZE     = 32,
  parameter int STEP     = 2,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hcnt,
  input  logic [9:0] vcnt,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       bg_r,
  input  logic       bg_g,
  input  logic       bg_b,
  input  logic       run,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       r,
  output logic       g,
  output logic       b
);

  import vga_pkg::*;

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE - SIZE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE - SIZE);

  logic [9:0] x, y;
  logic       dx, dy;
  logic       bx, by;
  logic       tick, upd;
  logic       hit;
  rgb_t       colour;

  // Updates only on the first blanked line so the sprite never tears mid-frame
  assign tick = (hcnt == '0) && (vcnt == 10'(V_ACTIVE));
  assign upd  = tick && run;

  vga_bounce_axis #(.STEP(STEP)) u_x (
    .clk(clk), .rst(rst), .upd(upd), .limit(H_LIM),
    .pos(x), .dir(dx), .bounce(bx)
  );

  vga_bounce_axis #(.STEP(STEP)) u_y (
    .clk(clk), .rst(rst), .upd(upd), .limit(V_LIM),
    .pos(y), .dir(dy), .bounce(by)
  );

`ifdef VGA_BOUNCE_COLOR_CYCLE_EN
  // A corner hit (bx and by together) advances the colour only once
  always_ff @(posedge clk) begin
    if (rst) begin
      colour <= 3'b001;
    end else if (bx || by) begin
      colour <= (colour == 3'b111) ? 3'b001 : colour + 3'd1;
    end
  end
`else
  assign colour = 3'b111;
`endif

  always_comb begin
    hit = ({1'b0, hcnt} >= {1'b0, x}) && ({1'b0, hcnt} < ({1'b0, x} + 11'(SIZE))) &&
          ({1'b0, vcnt} >= {1'b0, y}) && ({1'b0, vcnt} < ({1'b0, y} + 11'(SIZE))) &&
          ({1'b0, hcnt} < 11'(H_ACTIVE)) && ({1'b0, vcnt} < 11'(V_ACTIVE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {r, g, b} <= '0;
      hsync_o   <= 1'b1;
      vsync_o   <= 1'b1;
    end else begin
      {r, g, b} <= hit ? colour : {bg_r, bg_g, bg_b};
      hsync_o   <= hsync;
      vsync_o   <= vsync;
    end
  end

endmodule

// File: tb/tb_vga_bounce.sv
// Self-checking bench for vga_bounce: a default-sized instance and a small,
// odd-stepped instance (frequent clamps and corners) checked against a frame-level model.
module tb_vga_bounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, hsync, vsync, bg_r, bg_g, bg_b, run;
  logic [9:0] hcnt_a, vcnt_a, hcnt_b, vcnt_b;
  logic       hso_a, vso_a, r_a, g_a, b_a;
  logic       hso_b, vso_b, r_b, g_b, b_b;

  int checks = 0;
  int failures = 0;

  vga_bounce dut_a (
    .clk(clk), .rst(rst), .hcnt(hcnt_a), .vcnt(vcnt_a), .hsync(hsync), .vsync(vsync),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .run(run),
    .hsync_o(hso_a), .vsync_o(vso_a), .r(r_a), .g(g_a), .b(b_a)
  );

  vga_bounce #(.SIZE(5), .STEP(3), .H_ACTIVE(30), .V_ACTIVE(20)) dut_b (
    .clk(clk), .rst(rst), .hcnt(hcnt_b), .vcnt(vcnt_b), .hsync(hsync), .vsync(vsync),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .run(run),
    .hsync_o(hso_b), .vsync_o(vso_b), .r(r_b), .g(g_b), .b(b_b)
  );

`ifdef VGA_BOUNCE_COLOR_CYCLE_EN
  localparam int RST_COL = 1;
`else
  localparam int RST_COL = 7;
`endif

  // Reference model: one entry per instance
  int psz[2] = '{32, 5};
  int pst[2] = '{2, 3};
  int pha[2] = '{640, 30};
  int pva[2] = '{480, 20};
  int mx[2], my[2], mdx[2], mdy[2], mcol[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mdx[i] = 1; mdy[i] = 1; mcol[i] = RST_COL;
    end
  endfunction

  function automatic void model_tick();
    for (int i = 0; i < 2; i++) begin
      int hl = pha[i] - psz[i];
      int vl = pva[i] - psz[i];
      bit bnc = 0;
      if (mdx[i] == 1) begin
        if (mx[i] + pst[i] > hl) begin mx[i] = hl; mdx[i] = 0; bnc = 1; end
        else mx[i] = mx[i] + pst[i];
      end else begin
        if (mx[i] < pst[i]) begin mx[i] = 0; mdx[i] = 1; bnc = 1; end
        else mx[i] = mx[i] - pst[i];
      end
      if (mdy[i] == 1) begin
        if (my[i] + pst[i] > vl) begin my[i] = vl; mdy[i] = 0; bnc = 1; end
        else my[i] = my[i] + pst[i];
      end else begin
        if (my[i] < pst[i]) begin my[i] = 0; mdy[i] = 1; bnc = 1; end
        else my[i] = my[i] - pst[i];
      end
`ifdef VGA_BOUNCE_COLOR_CYCLE_EN
      if (bnc) mcol[i] = (mcol[i] == 7) ? 1 : mcol[i] + 1;
`endif
    end
  endfunction

  function automatic logic [2:0] exp_pix(int i, int h, int v, logic [2:0] bg);
    if (h >= mx[i] && h < mx[i] + psz[i] && v >= my[i] && v < my[i] + psz[i] &&
        h < pha[i] && v < pva[i])
      return 3'(mcol[i]);
    return bg;
  endfunction

  // Probe points straddling the sprite edges; k >= 6 picks a random pixel
  function automatic void probe_pt(int i, int k, output int h, output int v);
    case (k)
      0: begin h = mx[i];              v = my[i];              end
      1: begin h = mx[i] + psz[i] - 1; v = my[i] + psz[i] - 1; end
      2: begin h = mx[i] - 1;          v = my[i];              end
      3: begin h = mx[i] + psz[i];     v = my[i] + psz[i] - 1; end
      4: begin h = mx[i];              v = my[i] - 1;          end
      5: begin h = mx[i] + psz[i] - 1; v = my[i] + psz[i];     end
      default: begin h = int'($urandom_range(0, 1023)); v = int'($urandom_range(0, 1023)); end
    endcase
    h = h & 1023;
    v = v & 1023;
    if (h == 0 && v == pva[i]) v = 0;
  endfunction

  task automatic drive(input int ha, input int va, input int hb, input int vb,
                       input logic rn, input logic rs, input logic hs, input logic vs,
                       input logic [2:0] bg);
    @(negedge clk);
    hcnt_a = 10'(ha); vcnt_a = 10'(va);
    hcnt_b = 10'(hb); vcnt_b = 10'(vb);
    run = rn; rst = rs; hsync = hs; vsync = vs;
    {bg_r, bg_g, bg_b} = bg;
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic rn, input logic rs);
    drive(0, pva[0], 0, pva[1], rn, rs, 1'b1, 1'b1, 3'b000);
    if (rs) model_reset();
    else if (rn) model_tick();
  endtask

  task automatic test_reset();
    drive(5, 5, 5, 5, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111);
    checks++;
    if ({hso_a, vso_a, r_a, g_a, b_a} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_a got=%b exp=%b", {hso_a, vso_a, r_a, g_a, b_a}, 5'b11000);
    end
    checks++;
    if ({hso_b, vso_b, r_b, g_b, b_b} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_b got=%b exp=%b", {hso_b, vso_b, r_b, g_b, b_b}, 5'b11000);
    end
    model_reset();
    drive(5, 5, 2, 2, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
    checks++;
    if ({r_a, g_a, b_a} !== 3'(RST_COL)) begin
      failures++;
      $display("FAIL reset_colour_a got=%b exp=%b", {r_a, g_a, b_a}, 3'(RST_COL));
    end
    checks++;
    if ({r_b, g_b, b_b} !== exp_pix(1, 2, 2, 3'b000)) begin
      failures++;
      $display("FAIL reset_colour_b got=%b exp=%b", {r_b, g_b, b_b}, exp_pix(1, 2, 2, 3'b000));
    end
  endtask

  task automatic test_motion();
    logic [2:0] e;
    for (int t = 0; t < 3; t++) do_tick(1'b1, 1'b0);
    drive(6, 6, 9, 9, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010);
    e = exp_pix(0, 6, 6, 3'b010);
    checks++;
    if ({r_a, g_a, b_a} !== e) begin
      failures++;
      $display("FAIL motion_in_a got=%b exp=%b", {r_a, g_a, b_a}, e);
    end
    drive(5, 5, 8, 8, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010);
    e = exp_pix(0, 5, 5, 3'b010);
    checks++;
    if ({r_a, g_a, b_a} !== e) begin
      failures++;
      $display("FAIL motion_out_a got=%b exp=%b", {r_a, g_a, b_a}, e);
    end
    e = exp_pix(1, 8, 8, 3'b010);
    checks++;
    if ({r_b, g_b, b_b} !== e) begin
      failures++;
      $display("FAIL motion_out_b got=%b exp=%b", {r_b, g_b, b_b}, e);
    end
  endtask

  task automatic test_freeze();
    int ha, va, hb, vb;
    logic [2:0] bg, ea, eb;
    for (int t = 0; t < 4; t++) begin
      do_tick(1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
        probe_pt(0, k, ha, va);
        probe_pt(1, k, hb, vb);
        bg = 3'($urandom_range(0, 7));
        drive(ha, va, hb, vb, 1'b0, 1'b0, 1'b1, 1'b1, bg);
        ea = exp_pix(0, ha, va, bg);
        eb = exp_pix(1, hb, vb, bg);
        checks++;
        if ({r_a, g_a, b_a} !== ea) begin
          failures++;
          $display("FAIL freeze_a t=%0d k=%0d got=%b exp=%b", t, k, {r_a, g_a, b_a}, ea);
        end
        checks++;
        if ({r_b, g_b, b_b} !== eb) begin
          failures++;
          $display("FAIL freeze_b t=%0d k=%0d got=%b exp=%b", t, k, {r_b, g_b, b_b}, eb);
        end
      end
    end
  endtask

  // Outputs must hold across the input change and follow exactly one edge later
  task automatic test_sync();
    logic [4:0] prev, now;
    drive(700, 700, 1000, 1000, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
    prev = 5'b11000;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      hsync = (c < 96) ? 1'b1 : ((c < 150) ? 1'b0 : 1'b1);
      vsync = 1'($urandom_range(0, 1));
      {bg_r, bg_g, bg_b} = 3'($urandom_range(0, 7));
      now = {hsync, vsync, bg_r, bg_g, bg_b};
      #1;
      checks++;
      if ({hso_a, vso_a, r_a, g_a, b_a} !== prev) begin
        failures++;
        $display("FAIL sync_hold c=%0d got=%b exp=%b", c, {hso_a, vso_a, r_a, g_a, b_a}, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({hso_a, vso_a, r_a, g_a, b_a} !== now || {hso_b, vso_b, r_b, g_b, b_b} !== now) begin
        failures++;
        $display("FAIL sync_delay c=%0d got_a=%b got_b=%b exp=%b", c,
                 {hso_a, vso_a, r_a, g_a, b_a}, {hso_b, vso_b, r_b, g_b, b_b}, now);
      end
      prev = now;
    end
  endtask

  task automatic test_random();
    int ha, va, hb, vb;
    logic rn, hs, vs;
    logic [2:0] bg, ea, eb;
    for (int f = 0; f < 900; f++) begin
      rn = ($urandom_range(0, 7) != 0);
      bg = 3'($urandom_range(0, 7));
      drive(0, pva[0], 0, pva[1], rn, 1'b0, 1'b1, 1'b0, bg);
      ea = exp_pix(0, 0, pva[0], bg);
      checks++;
      if ({hso_a, vso_a, r_a, g_a, b_a} !== {2'b10, ea}) begin
        failures++;
        $display("FAIL tick_pix f=%0d got=%b exp=%b", f, {hso_a, vso_a, r_a, g_a, b_a}, {2'b10, ea});
      end
      if (rn) model_tick();
      for (int k = 0; k < 7; k++) begin
        probe_pt(0, k, ha, va);
        probe_pt(1, k, hb, vb);
        bg = 3'($urandom_range(0, 7));
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        drive(ha, va, hb, vb, rn, 1'b0, hs, vs, bg);
        ea = exp_pix(0, ha, va, bg);
        eb = exp_pix(1, hb, vb, bg);
        checks++;
        if ({hso_a, vso_a, r_a, g_a, b_a} !== {hs, vs, ea}) begin
          failures++;
          $display("FAIL rand_a f=%0d k=%0d pos=(%0d,%0d) got=%b exp=%b", f, k, mx[0], my[0],
                   {hso_a, vso_a, r_a, g_a, b_a}, {hs, vs, ea});
        end
        checks++;
        if ({hso_b, vso_b, r_b, g_b, b_b} !== {hs, vs, eb}) begin
          failures++;
          $display("FAIL rand_b f=%0d k=%0d pos=(%0d,%0d) got=%b exp=%b", f, k, mx[1], my[1],
                   {hso_b, vso_b, r_b, g_b, b_b}, {hs, vs, eb});
        end
      end
    end
  endtask

  task automatic test_reset_tick();
    int ha, va, hb, vb;
    logic [2:0] ea, eb;
    do_tick(1'b0, 1'b1);
    for (int t = 0; t < 50; t++) do_tick(1'b1, 1'b0);
    do_tick(1'b1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      probe_pt(0, k, ha, va);
      probe_pt(1, k, hb, vb);
      drive(ha, va, hb, vb, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
      ea = exp_pix(0, ha, va, 3'b000);
      eb = exp_pix(1, hb, vb, 3'b000);
      checks++;
      if ({r_a, g_a, b_a} !== ea) begin
        failures++;
        $display("FAIL rst_tick_a k=%0d got=%b exp=%b", k, {r_a, g_a, b_a}, ea);
      end
      checks++;
      if ({r_b, g_b, b_b} !== eb) begin
        failures++;
        $display("FAIL rst_tick_b k=%0d got=%b exp=%b", k, {r_b, g_b, b_b}, eb);
      end
    end
    drive(100, 100, 1000, 1000, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
    checks++;
    if ({r_a, g_a, b_a} !== 3'b000) begin
      failures++;
      $display("FAIL rst_tick_old_pos got=%b exp=%b", {r_a, g_a, b_a}, 3'b000);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; hsync = 1'b1; vsync = 1'b1;
    {bg_r, bg_g, bg_b} = 3'b000;
    hcnt_a = 10'd5; vcnt_a = 10'd5; hcnt_b = 10'd5; vcnt_b = 10'd5;
    model_reset();
    test_reset();
    test_motion();
    test_freeze();
    test_sync();
    test_random();
    test_reset_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
